spi_wb_top: RTL and testbench

SPI_WB_TOP -- requirements
Module: spi_wb_top

---
 rtl/spi_wb_top.sv | 165 ++++++++++++++++
 tb/tb_spi_wb_top.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_top.sv
// Wishbone-slave SPI master for a serial EEPROM: four registers, mode-0 SPI engine
// with programmable half-period, up to 4 TX bytes followed by up to 3 RX bytes.
module spi_wb_top #(
  parameter logic [7:0] DIV_DEFAULT = 8'd4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  ADR_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        SPI_MISO,
  output logic        SPI_MOSI,
  output logic        SPI_CLK,
  output logic        SPI_CS_N,
  output logic        SPI_WP_N,
  output logic        SPI_HOLD_N,
  output logic        SPI_RESET
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t      r_state;
  logic        r_ack, r_hold;
  logic [31:0] r_dat, r_tx, r_ctrl, r_rx, r_sh;
  logic        r_busy, r_done;
  logic [7:0]  r_div, r_hcnt;
  logic [5:0]  r_nbits, r_txbits, r_bit;
  logic        r_cs_n, r_sck, r_mosi;

  logic        w_acc, w_wr_cfg, w_start, w_tick, w_rx_phase;
  logic [2:0]  w_txcnt, w_nbytes;
  logic [1:0]  w_rxcnt;
  logic [31:0] w_rd;

  // A new access is accepted only once STB_I has dropped after the previous ACK.
  assign w_acc    = CYC_I & STB_I & ~r_ack & ~r_hold;
  assign w_wr_cfg = w_acc & WE_I & ~r_busy;
  assign w_txcnt  = (DAT_I[2:0] > 3'd4) ? 3'd4 : DAT_I[2:0];
  assign w_rxcnt  = DAT_I[4:3];
  assign w_nbytes = w_txcnt + {1'b0, w_rxcnt};
  assign w_start  = w_wr_cfg && (ADR_I == 8'h02) && DAT_I[8] && (w_nbytes != 3'd0);
  assign w_tick   = (r_hcnt == r_div);
  assign w_rx_phase = (r_bit >= r_txbits);

  always_comb begin
    w_rd = '0;
    case (ADR_I)
      8'h00:   w_rd = {30'd0, r_done, r_busy};
      8'h01:   w_rd = r_tx;
      8'h02:   w_rd = r_ctrl;
      8'h03:   w_rd = r_rx;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_ack  <= 1'b0;
      r_hold <= 1'b0;
      r_dat  <= '0;
      r_tx   <= '0;
      r_ctrl <= {8'h00, DIV_DEFAULT, 16'h0000};
    end else begin
      r_ack  <= w_acc;
      r_hold <= STB_I & (r_hold | r_ack);
      r_dat  <= w_acc ? w_rd : '0;
      if (w_wr_cfg && (ADR_I == 8'h01)) r_tx   <= DAT_I;
      if (w_wr_cfg && (ADR_I == 8'h02)) r_ctrl <= DAT_I;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_state  <= S_IDLE;
      r_cs_n   <= 1'b1;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rx     <= '0;
      r_sh     <= '0;
      r_div    <= '0;
      r_hcnt   <= '0;
      r_bit    <= '0;
      r_nbits  <= '0;
      r_txbits <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_SETUP;
            r_cs_n   <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_rx     <= '0;
            r_div    <= DAT_I[23:16];
            r_hcnt   <= '0;
            r_bit    <= '0;
            r_nbits  <= {w_nbytes, 3'b000};
            r_txbits <= {w_txcnt, 3'b000};
            r_mosi   <= (w_txcnt != 3'd0) & r_tx[31];
            r_sh     <= {r_tx[30:0], 1'b0};
          end
        end
        S_SETUP: begin
          if (w_tick) begin
            r_state <= S_SHIFT;
            r_sck   <= 1'b1;
            r_hcnt  <= '0;
            if (w_rx_phase) r_rx <= {r_rx[30:0], SPI_MISO};
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_hcnt <= '0;
            if (r_sck) begin
              r_sck <= 1'b0;
              r_bit <= r_bit + 6'd1;
              if ((r_bit + 6'd1) < r_txbits) begin
                r_mosi <= r_sh[31];
                r_sh   <= {r_sh[30:0], 1'b0};
              end else begin
                r_mosi <= 1'b0;
              end
            end else if (r_bit == r_nbits) begin
              r_state <= S_HOLD;
            end else begin
              r_sck <= 1'b1;
              if (w_rx_phase) r_rx <= {r_rx[30:0], SPI_MISO};
            end
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_state <= S_IDLE;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DAT_O      = r_dat;
  assign ACK_O      = r_ack;
  assign SPI_MOSI   = r_mosi;
  assign SPI_CLK    = r_sck;
  assign SPI_CS_N   = r_cs_n;
  assign SPI_WP_N   = 1'b1;
  assign SPI_HOLD_N = 1'b1;
  assign SPI_RESET  = ~RST_I;

endmodule

// File: tb/tb_spi_wb_top.sv
// Self-checking bench for spi_wb_top: register table, hand-written corner sequences,
// and randomized transfers checked against a bit-level SPI transaction model.
module tb_spi_wb_top;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [7:0]  ADR_I = '0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        SPI_MISO = 1'b0;
  logic        SPI_MOSI, SPI_CLK, SPI_CS_N, SPI_WP_N, SPI_HOLD_N, SPI_RESET;

  spi_wb_top #(.DIV_DEFAULT(8'd4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .SPI_MISO(SPI_MISO), .SPI_MOSI(SPI_MOSI), .SPI_CLK(SPI_CLK), .SPI_CS_N(SPI_CS_N),
    .SPI_WP_N(SPI_WP_N), .SPI_HOLD_N(SPI_HOLD_N), .SPI_RESET(SPI_RESET)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_errors = 0;

  // Bus-side observation of the SPI pins, shared with the stimulus thread.
  int          cs_low, pulses;
  logic [63:0] mosi_cap;
  logic [63:0] pat_g;
  logic        xfer_end;
  logic        prev_cs = 1'b1, prev_sck = 1'b0;
  int          mon_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // EEPROM stand-in: presents pattern bit k before SCK rise k, updating after each fall.
  initial begin
    forever begin
      @(negedge CLK_I);
      if (!SPI_CS_N) cs_low++;
      if (SPI_CLK && !prev_sck) begin
        pulses++;
        mosi_cap = {mosi_cap[62:0], SPI_MOSI};
      end
      if ((!SPI_CS_N && prev_cs) || (!SPI_CS_N && !SPI_CLK && prev_sck)) begin
        mon_idx = pulses;
        if (mon_idx < 64) SPI_MISO = pat_g[63 - mon_idx];
      end
      if (SPI_CS_N && !prev_cs) xfer_end = 1'b1;
      prev_cs  = SPI_CS_N;
      prev_sck = SPI_CLK;
    end
  end

  task automatic arm(input logic [63:0] pat);
    cs_low   = 0;
    pulses   = 0;
    mosi_cap = '0;
    xfer_end = 1'b0;
    pat_g    = pat;
  endtask

  task automatic wb_access(input logic we, input logic [7:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic ok);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        ok = 1'b1;
        rd = DAT_O;
        break;
      end
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] wd);
    logic [31:0] rd;
    logic ok;
    wb_access(1'b1, adr, wd, rd, ok);
    check($sformatf("ack_wr_%0h", adr), {63'd0, ok}, 64'd1);
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] rd);
    logic ok;
    wb_access(1'b0, adr, 32'd0, rd, ok);
    check($sformatf("ack_rd_%0h", adr), {63'd0, ok}, 64'd1);
  endtask

  task automatic held_access(input logic we, input logic [7:0] adr, input logic [31:0] wd,
                             output int acks, output logic [31:0] rd);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
    acks = 0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        acks++;
        rd = DAT_O;
      end
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  // Model: CS low 2H per bit plus 2H, one SCK pulse per bit, TX bytes MSB-first then
  // zeros on MOSI, RX = pattern bits seen during the RX pulses, right-justified.
  task automatic check_xfer(input logic [31:0] tx, input logic [31:0] ctrl, output logic [31:0] rx);
    int unsigned teff, rcnt, h, n;
    logic [63:0] exp_mosi;
    logic [31:0] exp_rx, st;
    teff = (ctrl[2:0] > 3'd4) ? 4 : int'(ctrl[2:0]);
    rcnt = int'(ctrl[4:3]);
    h    = int'(ctrl[23:16]) + 1;
    n    = 8 * (teff + rcnt);
    exp_mosi = '0;
    exp_rx   = '0;
    for (int unsigned i = 0; i < n; i++) begin
      exp_mosi = {exp_mosi[62:0], (i < 8 * teff) ? tx[31 - i] : 1'b0};
      if (i >= 8 * teff) exp_rx = {exp_rx[30:0], pat_g[63 - i]};
    end
    for (int i = 0; i < 4000 && !xfer_end; i++) @(negedge CLK_I);
    check("xfer_end", {63'd0, xfer_end}, 64'd1);
    check("cs_low_cycles", 64'(cs_low), 64'(2 * h * n + 2 * h));
    check("sck_pulses", 64'(pulses), 64'(n));
    check("mosi_bits", mosi_cap, exp_mosi);
    wb_read(8'h03, rx);
    check("rxdata", {32'd0, rx}, {32'd0, exp_rx});
    wb_read(8'h00, st);
    check("status_done", {32'd0, st}, 64'd2);
  endtask

  task automatic run_xfer(input logic [31:0] tx, input logic [31:0] ctrl,
                          input logic [63:0] pat, output logic [31:0] rx);
    logic [31:0] rb;
    arm(pat);
    wb_write(8'h01, tx);
    wb_write(8'h02, ctrl);
    check_xfer(tx, ctrl, rx);
    wb_read(8'h02, rb);
    check("ctrl_readback", {32'd0, rb}, {32'd0, ctrl});
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[13];
  logic [31:0] rd, rx;
  int          acks;

  initial begin
    vt[0]  = '{1'b0, 8'h02, 32'h0, 32'h0004_0000};
    vt[1]  = '{1'b0, 8'h01, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 8'h00, 32'h0, 32'h0};
    vt[3]  = '{1'b0, 8'h03, 32'h0, 32'h0};
    vt[4]  = '{1'b1, 8'h01, 32'h4154_A000, 32'h0};
    vt[5]  = '{1'b0, 8'h01, 32'h0, 32'h4154_A000};
    vt[6]  = '{1'b1, 8'h02, 32'h0007_0018, 32'h0};
    vt[7]  = '{1'b0, 8'h02, 32'h0, 32'h0007_0018};
    vt[8]  = '{1'b1, 8'h7F, 32'hFFFF_FFFF, 32'h0};
    vt[9]  = '{1'b0, 8'h7F, 32'h0, 32'h0};
    vt[10] = '{1'b0, 8'h01, 32'h0, 32'h4154_A000};
    vt[11] = '{1'b0, 8'h02, 32'h0, 32'h0007_0018};
    vt[12] = '{1'b0, 8'h00, 32'h0, 32'h0};
    arm('0);

    // Reset state
    repeat (3) @(negedge CLK_I);
    check("rst_cs_n", {63'd0, SPI_CS_N}, 64'd1);
    check("rst_sck", {63'd0, SPI_CLK}, 64'd0);
    check("rst_mosi", {63'd0, SPI_MOSI}, 64'd0);
    check("rst_ack", {63'd0, ACK_O}, 64'd0);
    check("rst_dat_o", {32'd0, DAT_O}, 64'd0);
    check("rst_wp_hold", {62'd0, SPI_WP_N, SPI_HOLD_N}, 64'd3);
    check("rst_spi_reset", {63'd0, SPI_RESET}, 64'd1);
    RST_I = 1'b1;
    @(negedge CLK_I);
    check("spi_reset_rel", {63'd0, SPI_RESET}, 64'd0);

    foreach (vt[i]) begin
      if (vt[i].we) begin
        wb_write(vt[i].adr, vt[i].wd);
      end else begin
        wb_read(vt[i].adr, rd);
        check($sformatf("vec%0d_rd", i), {32'd0, rd}, {32'd0, vt[i].exp});
      end
    end

    // Held strobe: one ACK per access, DAT_O back to 0 afterwards
    held_access(1'b1, 8'h01, 32'h4154_A000, acks, rd);
    check("held_wr_acks", 64'(acks), 64'd1);
    held_access(1'b0, 8'h01, 32'h0, acks, rd);
    check("held_rd_acks", 64'(acks), 64'd1);
    check("held_rd_data", {32'd0, rd}, 64'h4154_A000);
    @(negedge CLK_I);
    check("dat_o_idle", {32'd0, DAT_O}, 64'd0);

    // WREN, write, read-back sequence with DIV=0
    run_xfer(32'h0600_0000, 32'h0000_0101, 64'd0, rx);
    run_xfer(32'h0205_5A00, 32'h0000_0103, 64'd0, rx);
    run_xfer(32'h0305_0000, 32'h0000_010A, 64'h0000_5A00_0000_0000, rx);
    check("eeprom_read", {32'd0, rx}, 64'h5A);

    // Start with both counts zero: nothing happens, done stays set
    arm('0);
    wb_write(8'h02, 32'h0003_0100);
    repeat (10) @(negedge CLK_I);
    check("noop_cs", 64'(cs_low), 64'd0);
    wb_read(8'h00, rd);
    check("noop_status", {32'd0, rd}, 64'd2);

    // Config writes during a transfer are acknowledged but ignored
    arm({$urandom, $urandom});
    wb_write(8'h01, 32'h1234_5678);
    wb_write(8'h02, 32'h0003_0102);
    wb_read(8'h00, rd);
    check("mid_status_busy", {32'd0, rd}, 64'd1);
    wb_write(8'h02, 32'h0000_0101);
    wb_write(8'h01, 32'hFFFF_FFFF);
    wb_read(8'h02, rd);
    check("mid_ctrl_kept", {32'd0, rd}, 64'h0003_0102);
    wb_read(8'h01, rd);
    check("mid_tx_kept", {32'd0, rd}, 64'h1234_5678);
    check_xfer(32'h1234_5678, 32'h0003_0102, rx);

    // Randomized transfers, including TX counts above 4
    for (int k = 0; k < 8; k++) begin
      int unsigned t, r, dv;
      logic [31:0] ctrl, tx;
      t  = $urandom_range(0, 7);
      r  = $urandom_range(0, 3);
      dv = $urandom_range(0, 3);
      if (t == 0 && r == 0) r = 1;
      ctrl = {8'h00, dv[7:0], 7'd0, 1'b1, 3'd0, r[1:0], t[2:0]};
      tx   = $urandom;
      run_xfer(tx, ctrl, {$urandom, $urandom}, rx);
    end

    // Reset mid-transfer aborts it
    arm({$urandom, $urandom});
    wb_write(8'h01, 32'hA5A5_A5A5);
    wb_write(8'h02, 32'h0002_0104);
    repeat (20) @(negedge CLK_I);
    RST_I = 1'b0;
    @(negedge CLK_I);
    check("abort_cs_n", {63'd0, SPI_CS_N}, 64'd1);
    check("abort_sck", {63'd0, SPI_CLK}, 64'd0);
    check("abort_spi_reset", {63'd0, SPI_RESET}, 64'd1);
    check("abort_wp_hold", {62'd0, SPI_WP_N, SPI_HOLD_N}, 64'd3);
    RST_I = 1'b1;
    wb_read(8'h00, rd);
    check("abort_status", {32'd0, rd}, 64'd0);
    wb_read(8'h03, rd);
    check("abort_rx", {32'd0, rd}, 64'd0);
    wb_read(8'h02, rd);
    check("abort_ctrl", {32'd0, rd}, 64'h0004_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
